// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants and FSM encoding for the MNIST inference sequencer
//
// Contents:
//   N_PIXELS_DEF / N_CLASSES_DEF / DATA_W_DEF : default sizing for one pass
//   seq_state_e                               : run-controller state encoding
package mnist_pkg;

    localparam int N_PIXELS_DEF  = 784;
    localparam int N_CLASSES_DEF = 10;
    localparam int DATA_W_DEF    = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAYER  = 3'd2,
        S_ARGMAX = 3'd3,
        S_FINISH = 3'd4
    } seq_state_e;

endpackage

// File: rtl/argmax_unit.sv
// rtl/argmax_unit.sv - running signed argmax over a stream of class scores
//
// Ports:
//   clk        : clock, rising edge
//   clear      : synchronous clear of best and count (held while the sequencer is idle)
//   valid      : one accepted score beat this cycle
//   data       : score, two's-complement signed
//   best_idx   : index of the best score so far
//   best_score : best score so far
//   count      : number of beats accepted since clear
module argmax_unit import mnist_pkg::*; #(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             valid,
    input  logic [DATA_W-1:0]                data,
    output logic [3:0]                       best_idx,
    output logic [DATA_W-1:0]                best_score,
    output logic [$clog2(N_CLASSES+1)-1:0]   count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            best_idx   <= '0;
            best_score <= '0;
            count      <= '0;
        end else if (valid) begin
            // First beat always seeds best; later beats need strictly greater,
            // so an equal score never displaces a lower index.
            if (count == '0 || $signed(data) > $signed(best_score)) begin
                best_score <= data;
                best_idx   <= 4'(count);
            end
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/inference_sequencer.sv
// rtl/inference_sequencer.sv - run controller for one MNIST inference pass
//
// Ports:
//   s_axi_aclk, s_axi_areset : clock and synchronous active-high reset
//   cmd_start, cmd_abort     : run request (rising edge) and abort
//   ldr_start                : start level to the pixel loader
//   ldr_tvalid, ldr_tready   : monitored pixel stream handshake
//   layer_start, layer_done  : one-hot start pulse / completion pulse per layer
//   y_tdata, y_tvalid, y_tready : class score stream
//   busy, done, err_timeout  : run status (done/err_timeout sticky)
//   pred_class, pred_score   : argmax result of the last completed run
//   cycle_count              : cycles from start acceptance to entering FINISH
module inference_sequencer import mnist_pkg::*; #(
    parameter int N_PIXELS       = N_PIXELS_DEF,
    parameter int NUM_LAYERS     = 2,
    parameter int N_CLASSES      = N_CLASSES_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_areset,
    input  logic                  cmd_start,
    input  logic                  cmd_abort,
    output logic                  ldr_start,
    input  logic                  ldr_tvalid,
    input  logic                  ldr_tready,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [DATA_W-1:0]     y_tdata,
    input  logic                  y_tvalid,
    output logic                  y_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic [3:0]            pred_class,
    output logic [DATA_W-1:0]     pred_score,
    output logic [31:0]           cycle_count
);

    localparam int PIX_W  = $clog2(N_PIXELS+1);
    localparam int CLS_W  = $clog2(N_CLASSES+1);
    localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES+1);

    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(N_PIXELS-1);
    localparam logic [CLS_W-1:0]  CLS_LAST   = CLS_W'(N_CLASSES-1);
    localparam logic [LIDX_W-1:0] LAYER_LAST = LIDX_W'(NUM_LAYERS-1);
    localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_LOAD   = S_LOAD;
    localparam logic [2:0] ST_LAYER  = S_LAYER;
    localparam logic [2:0] ST_ARGMAX = S_ARGMAX;
    localparam logic [2:0] ST_FINISH = S_FINISH;

    logic [2:0]        state;
    logic              cmd_start_q;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LIDX_W-1:0] layer_idx;
    logic [LIDX_W-1:0] next_idx;
    logic [WD_W-1:0]   wdog;
    logic [WD_W-1:0]   wdog_next;
    logic [3:0]        best_idx;
    logic [DATA_W-1:0] best_score;
    logic [CLS_W-1:0]  cls_cnt;

    logic start_edge, pix_beat, y_beat, layer_hit, waiting, wdog_expire;

    assign start_edge = cmd_start & ~cmd_start_q;
    assign pix_beat   = (state == ST_LOAD) & ldr_tvalid & ldr_tready;
    assign y_beat     = (state == ST_ARGMAX) & y_tvalid & y_tready;
    assign layer_hit  = (state == ST_LAYER) & layer_done[layer_idx];
    assign waiting    = (state == ST_LOAD) | (state == ST_LAYER) | (state == ST_ARGMAX);
    assign next_idx   = layer_idx + 1'b1;
    assign wdog_next  = wdog + 1'b1;
    // Any forward progress in a wait state counts as activity and rearms the watchdog.
    assign wdog_expire = waiting & ~(pix_beat | layer_hit | y_beat) & (wdog_next == WD_LIMIT);

    argmax_unit #(
        .N_CLASSES (N_CLASSES),
        .DATA_W    (DATA_W)
    ) u_argmax (
        .clk        (s_axi_aclk),
        .clear      (s_axi_areset | (state == ST_IDLE)),
        .valid      (y_beat),
        .data       (y_tdata),
        .best_idx   (best_idx),
        .best_score (best_score),
        .count      (cls_cnt)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state       <= ST_IDLE;
            cmd_start_q <= 1'b0;
            pix_cnt     <= '0;
            layer_idx   <= '0;
            wdog        <= '0;
            ldr_start   <= 1'b0;
            layer_start <= '0;
            y_tready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            pred_class  <= '0;
            pred_score  <= '0;
            cycle_count <= '0;
        end else begin
            cmd_start_q <= cmd_start;
            layer_start <= '0;
            if (waiting && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;

            if (cmd_abort) begin
                // In IDLE an abort only masks a coincident start edge.
                if (busy) begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    err_timeout <= 1'b0;
                    ldr_start   <= 1'b0;
                    y_tready    <= 1'b0;
                    wdog        <= '0;
                end
            end else if (wdog_expire) begin
                state       <= ST_IDLE;
                err_timeout <= 1'b1;
                busy        <= 1'b0;
                ldr_start   <= 1'b0;
                y_tready    <= 1'b0;
                wdog        <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_edge) begin
                            state       <= ST_LOAD;
                            busy        <= 1'b1;
                            ldr_start   <= 1'b1;
                            done        <= 1'b0;
                            err_timeout <= 1'b0;
                            pix_cnt     <= '0;
                            layer_idx   <= '0;
                            wdog        <= '0;
                            cycle_count <= '0;
                        end
                    end
                    ST_LOAD: begin
                        if (pix_beat) begin
                            // Holding start until the first accepted beat guarantees
                            // the loader saw it while the stream was ready.
                            ldr_start <= 1'b0;
                            pix_cnt   <= pix_cnt + 1'b1;
                            wdog      <= '0;
                            if (pix_cnt == PIX_LAST) begin
                                state          <= ST_LAYER;
                                layer_start[0] <= 1'b1;
                            end
                        end else begin
                            wdog <= wdog_next;
                        end
                    end
                    ST_LAYER: begin
                        if (layer_hit) begin
                            wdog <= '0;
                            if (layer_idx == LAYER_LAST) begin
                                state    <= ST_ARGMAX;
                                y_tready <= 1'b1;
                            end else begin
                                layer_idx             <= next_idx;
                                layer_start[next_idx] <= 1'b1;
                            end
                        end else begin
                            wdog <= wdog_next;
                        end
                    end
                    ST_ARGMAX: begin
                        if (y_beat) begin
                            wdog <= '0;
                            if (cls_cnt == CLS_LAST) begin
                                state    <= ST_FINISH;
                                y_tready <= 1'b0;
                            end
                        end else begin
                            wdog <= wdog_next;
                        end
                    end
                    ST_FINISH: begin
                        pred_class <= best_idx;
                        pred_score <= best_score;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb/tb_inference_sequencer.sv - scoreboard bench for inference_sequencer
module tb_inference_sequencer;

    localparam int NPIX = 784;
    localparam int TMO  = 100;

    typedef logic signed [31:0] score_arr_t [10];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0, cmd_abort = 1'b0;
    logic        ldr_start, ldr_tvalid = 1'b0, ldr_tready = 1'b0;
    logic [1:0]  layer_start, layer_done = 2'b00;
    logic [31:0] y_tdata = '0;
    logic        y_tvalid = 1'b0, y_tready;
    logic        busy, done, err_timeout;
    logic [3:0]  pred_class;
    logic [31:0] pred_score, cycle_count;

    int total = 0, bad = 0;
    int ecnt = 0, ls0 = 0, ls1 = 0;
    int          exp_cls_q[$];
    logic [31:0] exp_score_q[$];
    int          last_cls = 0;
    logic [31:0] last_score = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ecnt++;
        if (layer_start[0]) ls0++;
        if (layer_start[1]) ls1++;
    end

    inference_sequencer #(
        .N_PIXELS(NPIX), .NUM_LAYERS(2), .N_CLASSES(10), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .ldr_start(ldr_start), .ldr_tvalid(ldr_tvalid), .ldr_tready(ldr_tready),
        .layer_start(layer_start), .layer_done(layer_done),
        .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tready(y_tready),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .pred_class(pred_class), .pred_score(pred_score), .cycle_count(cycle_count)
    );

    function automatic void model(input score_arr_t s, output int ci, output logic [31:0] bs);
        logic signed [31:0] b;
        ci = 0;
        b  = s[0];
        for (int i = 1; i < 10; i++)
            if (s[i] > b) begin b = s[i]; ci = i; end
        bs = b;
    endfunction

    task automatic start_run(output int e0);
        @(negedge clk);
        cmd_start = 1'b1;
        e0 = ecnt + 1;
        ls0 = 0; ls1 = 0;
        @(negedge clk);
        cmd_start = 1'b0;
        total++;
        if ({busy, ldr_start, done, err_timeout} !== 4'b1100) begin
            bad++;
            $display("FAIL start_accept busy/ldr/done/err got=%b want=1100",
                     {busy, ldr_start, done, err_timeout});
        end
    endtask

    task automatic load_pixels(input bit toggle, input int abort_at, output bit aborted);
        int beats = 0, cyc = 0;
        bit bt, early = 0;
        aborted = 0;
        while (beats < NPIX) begin
            if (abort_at >= 0 && beats == abort_at) begin
                ldr_tvalid = 1'b0; ldr_tready = 1'b0; cmd_abort = 1'b1;
                @(negedge clk);
                cmd_abort = 1'b0;
                total++;
                if ({busy, ldr_start, done, err_timeout} !== 4'b0000) begin
                    bad++;
                    $display("FAIL abort_state busy/ldr/done/err got=%b want=0000",
                             {busy, ldr_start, done, err_timeout});
                end
                total++;
                if (pred_class !== last_cls[3:0] || pred_score !== last_score) begin
                    bad++;
                    $display("FAIL abort_pred got=%0d/%0d want=%0d/%0d",
                             pred_class, $signed(pred_score), last_cls, $signed(last_score));
                end
                aborted = 1;
                return;
            end
            ldr_tvalid = 1'b1;
            ldr_tready = toggle ? cyc[0] : 1'b1;
            bt = ldr_tready;
            cyc++;
            @(negedge clk);
            if (bt) begin
                beats++;
                if (beats == 1) begin
                    total++;
                    if (ldr_start !== 1'b0) begin
                        bad++;
                        $display("FAIL ldr_start_drop got=%b want=0", ldr_start);
                    end
                end
            end else if (beats == 0) begin
                total++;
                if (ldr_start !== 1'b1) begin
                    bad++;
                    $display("FAIL ldr_start_hold got=%b want=1", ldr_start);
                end
            end
            if (beats < NPIX && layer_start !== 2'b00) early = 1;
        end
        ldr_tvalid = 1'b0; ldr_tready = 1'b0;
        total++;
        if (layer_start !== 2'b01) begin
            bad++;
            $display("FAIL layer0_start got=%b want=01", layer_start);
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL layer0_early got=%b want=0", early);
        end
    endtask

    task automatic run_layers(input bit spurious, input bit withhold1);
        int k;
        for (int i = 0; i < 19; i++) begin
            if (spurious && i == 5) layer_done = 2'b10;
            @(negedge clk);
            layer_done = 2'b00;
        end
        layer_done = 2'b01;
        @(negedge clk);
        layer_done = 2'b00;
        total++;
        if (layer_start !== 2'b10) begin
            bad++;
            $display("FAIL layer1_start got=%b want=10", layer_start);
        end
        if (withhold1) begin
            k = 0;
            while (err_timeout !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            total++;
            if (k != TMO) begin
                bad++;
                $display("FAIL timeout_cycle got=%0d want=%0d", k, TMO);
            end
            return;
        end
        repeat (29) @(negedge clk);
        layer_done = 2'b10;
        @(negedge clk);
        layer_done = 2'b00;
        total++;
        if (y_tready !== 1'b1) begin
            bad++;
            $display("FAIL argmax_ready got=%b want=1", y_tready);
        end
    endtask

    task automatic send_scores(input score_arr_t s, input bit restart);
        for (int i = 0; i < 10; i++) begin
            y_tdata  = s[i];
            y_tvalid = 1'b1;
            if (restart && i == 3) cmd_start = 1'b1;
            if (restart && i == 5) cmd_start = 1'b0;
            @(negedge clk);
        end
        y_tvalid = 1'b0;
        cmd_start = 1'b0;
        total++;
        if (y_tready !== 1'b0) begin
            bad++;
            $display("FAIL argmax_drop got=%b want=0", y_tready);
        end
        @(negedge clk);
    endtask

    task automatic full_run(input score_arr_t s, input bit toggle, input bit spurious, input bit restart);
        int ci, e0, ec;
        logic [31:0] bs, es;
        bit ab;
        model(s, ci, bs);
        exp_cls_q.push_back(ci);
        exp_score_q.push_back(bs);
        start_run(e0);
        load_pixels(toggle, -1, ab);
        run_layers(spurious, 1'b0);
        send_scores(s, restart);
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL run_done busy/done got=%b%b want=01", busy, done);
        end
        total++;
        if (exp_cls_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=0 entries want=1");
        end else begin
            ec = exp_cls_q.pop_front();
            es = exp_score_q.pop_front();
            if (pred_class !== ec[3:0] || pred_score !== es) begin
                bad++;
                $display("FAIL pred got=%0d/%0d want=%0d/%0d",
                         pred_class, $signed(pred_score), ec, $signed(es));
            end
        end
        total++;
        if (cycle_count !== 32'(ecnt - e0 - 1)) begin
            bad++;
            $display("FAIL cycle_count got=%0d want=%0d", cycle_count, ecnt - e0 - 1);
        end
        total++;
        if (ls0 != 1 || ls1 != 1) begin
            bad++;
            $display("FAIL layer_pulses got=%0d/%0d want=1/1", ls0, ls1);
        end
        last_cls = ci;
        last_score = bs;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ldr_start, layer_start, y_tready, busy, done, err_timeout,
             pred_class, pred_score, cycle_count} !== 75'b0) begin
            bad++;
            $display("FAIL reset_outputs got=busy%b done%b pred%0d cc%0d want=all zero",
                     busy, done, pred_class, cycle_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal;
        score_arr_t s;
        s = '{5, -3, 9, 2, 9, 0, 1, -8, 4, 7};
        full_run(s, 1'b0, 1'b0, 1'b0);
        total++;
        if (pred_class !== 4'd2 || pred_score !== 32'd9) begin
            bad++;
            $display("FAIL nominal_const got=%0d/%0d want=2/9", pred_class, $signed(pred_score));
        end
    endtask

    task automatic test_backpressure;
        score_arr_t s;
        for (int i = 0; i < 10; i++) s[i] = $signed($urandom_range(0, 40)) - 20;
        full_run(s, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_all_negative;
        score_arr_t s;
        s = '{-10, -2, -2, -5, -9, -7, -3, -4, -6, -8};
        full_run(s, 1'b0, 1'b0, 1'b0);
        total++;
        if (pred_class !== 4'd1 || pred_score !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL negative_const got=%0d/%0d want=1/-2", pred_class, $signed(pred_score));
        end
    endtask

    task automatic test_timeout;
        int e0;
        bit ab;
        start_run(e0);
        load_pixels(1'b0, -1, ab);
        run_layers(1'b0, 1'b1);
        total++;
        if ({err_timeout, busy, done, ldr_start, y_tready} !== 5'b10000) begin
            bad++;
            $display("FAIL timeout_state err/busy/done/ldr/ytr got=%b want=10000",
                     {err_timeout, busy, done, ldr_start, y_tready});
        end
        total++;
        if (pred_class !== last_cls[3:0] || pred_score !== last_score) begin
            bad++;
            $display("FAIL timeout_pred got=%0d/%0d want=%0d/%0d",
                     pred_class, $signed(pred_score), last_cls, $signed(last_score));
        end
    endtask

    task automatic test_abort;
        int e0;
        bit ab;
        score_arr_t s;
        @(negedge clk);
        cmd_start = 1'b1; cmd_abort = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_abort = 1'b0;
        total++;
        if (busy !== 1'b0 || ldr_start !== 1'b0) begin
            bad++;
            $display("FAIL abort_wins busy/ldr got=%b%b want=00", busy, ldr_start);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_queue busy got=%b want=0", busy);
        end
        start_run(e0);
        load_pixels(1'b0, 300, ab);
        s = '{5, -3, 9, 2, 9, 0, 1, -8, 4, 7};
        full_run(s, 1'b0, 1'b0, 1'b0);
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL abort_rerun_err got=%b want=0", err_timeout);
        end
    endtask

    task automatic test_ignored;
        score_arr_t s;
        s = '{-1, 4, 11, 3, 11, 2, 0, 10, 7, 12};
        full_run(s, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        int e0;
        bit ab;
        start_run(e0);
        load_pixels(1'b0, -1, ab);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({ldr_start, layer_start, y_tready, busy, done, err_timeout,
             pred_class, pred_score, cycle_count} !== 75'b0) begin
            bad++;
            $display("FAIL reset_mid got=busy%b pred%0d/%0d cc%0d want=all zero",
                     busy, pred_class, $signed(pred_score), cycle_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_all_negative();
        test_timeout();
        test_abort();
        test_ignored();
        test_reset_mid_run();
        total++;
        if (exp_cls_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_cls_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
